// File: rtl/tag_pkg.sv
// Shared constants and types for the tag return path.
// TAG_RET_CHECK_EN enables the duplicate-return bitmap checker.
package tag_pkg;
  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 6;
  localparam int NUM_TAGS   = 64;
  localparam int SRC_W      = $clog2(NUM_SRC);

  typedef logic [DATA_WIDTH-1:0] tag_t;
  typedef logic [SRC_W-1:0]      src_id_t;

  localparam src_id_t RR_RESET = '0;
endpackage

// File: rtl/tag_ret_queue.sv
// Two-entry holding queue for one completion source.
// Ready depends only on registered occupancy.
module tag_ret_queue #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq,
  input  logic [W-1:0] enq_tag,
  input  logic         deq,
  output logic         ready,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         hd;
  logic         tl;
  logic         enq_ok;
  logic         deq_ok;

  assign ready  = (count != 2'd2);
  assign enq_ok = enq & ready;
  assign deq_ok = deq & (count != 2'd0);
  assign head   = mem[hd];

  always_ff @(posedge clk) begin
    if (enq_ok) mem[tl] <= enq_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd    <= 1'b0;
      tl    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq_ok) tl <= ~tl;
      if (deq_ok) hd <= ~hd;
      unique case ({enq_ok, deq_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tag_return_arbiter.sv
// Round-robin merge of completion tags into the tag FIFO write port,
// dispatch pop sequencing, outstanding counter; TAG_RET_CHECK_EN checker.
module tag_return_arbiter
  import tag_pkg::*;
#(
  parameter int NUM_SRC    = tag_pkg::NUM_SRC,
  parameter int DATA_WIDTH = tag_pkg::DATA_WIDTH,
  parameter int NUM_TAGS   = tag_pkg::NUM_TAGS,
  localparam int CW        = $clog2(NUM_TAGS) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tag,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         cdb_tag_tf,
  output logic                          cdb_tag_tf_valid,
  input  logic                          ff_tf,
  input  logic                          ef_tf,
  input  logic [DATA_WIDTH-1:0]         tagout_tf,
  output logic                          ren_tf,
  input  logic                          disp_req,
  output logic                          disp_gnt,
  output logic [DATA_WIDTH-1:0]         disp_tag,
  output logic [CW-1:0]                 outst_cnt,
  output logic                          err_dup_ret
);
  logic [DATA_WIDTH-1:0] heads [NUM_SRC];
  logic [1:0]            cnts  [NUM_SRC];
  logic [NUM_SRC-1:0]    pop;
  src_id_t               rr_ptr;
  src_id_t               win;
  logic                  found;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_q
    tag_ret_queue #(.W(DATA_WIDTH)) u_q (
      .clk     (clk),
      .rst     (rst),
      .enq     (src_valid[g]),
      .enq_tag (src_tag[g*DATA_WIDTH +: DATA_WIDTH]),
      .deq     (pop[g]),
      .ready   (src_ready[g]),
      .head    (heads[g]),
      .count   (cnts[g])
    );
  end

  // Search upward from rr_ptr; first non-empty queue wins.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = rr_ptr;
    pop   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!found && !ff_tf && cnts[idx] != 2'd0) begin
        found = 1'b1;
        win   = src_id_t'(idx);
      end
    end
    if (found) pop[win] = 1'b1;
  end

  assign cdb_tag_tf_valid = found;
  assign cdb_tag_tf       = found ? heads[win] : '0;

  assign disp_gnt = disp_req & ~ef_tf & ~rst;
  assign ren_tf   = disp_gnt;
  assign disp_tag = disp_gnt ? tagout_tf : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= RR_RESET;
    end else if (found) begin
      rr_ptr <= (win == src_id_t'(NUM_SRC-1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= '0;
    end else begin
      unique case ({disp_gnt, found})
        2'b10: if (outst_cnt != CW'(NUM_TAGS)) outst_cnt <= outst_cnt + 1'b1;
        2'b01: if (outst_cnt != '0) outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

`ifdef TAG_RET_CHECK_EN
  logic [NUM_TAGS-1:0] bitmap;
  logic                err_q;

  // Clear is written after set, so a same-cycle grant+return clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap <= '0;
      err_q  <= 1'b0;
    end else begin
      if (disp_gnt) bitmap[disp_tag] <= 1'b1;
      if (found) begin
        bitmap[cdb_tag_tf] <= 1'b0;
        if (!bitmap[cdb_tag_tf] && !(disp_gnt && disp_tag == cdb_tag_tf))
          err_q <= 1'b1;
      end
    end
  end

  assign err_dup_ret = err_q;
`else
  assign err_dup_ret = 1'b0;
`endif
endmodule
